// File: rtl/alarm_state_encoder.sv
// Sensor-side alarm word producer: synchronise, debounce and latch smoke/motion/moisture events until acked.
// Optional build macro ALARM_SELFTEST_EN adds a `selftest` input that forces the visible word to 111.
module alarm_state_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       smoke_raw,
  input  logic       motion_raw,
  input  logic       moisture_raw,
  input  logic       armed,
`ifdef ALARM_SELFTEST_EN
  input  logic       selftest,
`endif
  input  logic [2:0] ack,
  output logic [2:0] state,
  output logic       state_chg,
  output logic       any_alarm
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    LATCHED  = 2'd2,
    WAIT_LOW = 2'd3
  } chan_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: [2]=fire, [1]=burglar, [0]=rain.
  logic [2:0]              raw;
  logic [2:0]              enable;
  logic [2:0]              sync1_q;
  logic [2:0]              syn_q;
  chan_state_e [2:0]       fsm_q;
  chan_state_e [2:0]       fsm_nxt;
  logic [2:0][CNT_W-1:0]   cnt_q;
  logic [2:0][CNT_W-1:0]   cnt_nxt;
  logic [2:0]              latch_nxt;
  logic [2:0]              vis_nxt;
  logic [2:0]              prev_q;
  logic                    force_all;

  assign raw    = {smoke_raw, motion_raw, moisture_raw};
  assign enable = {1'b1, armed, 1'b1};

`ifdef ALARM_SELFTEST_EN
  assign force_all = selftest;
`else
  assign force_all = 1'b0;
`endif

  // Per-channel next state; the disarmed burglar channel is held in IDLE unless already latched.
  always_comb begin
    fsm_nxt   = fsm_q;
    cnt_nxt   = cnt_q;
    latch_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      case (fsm_q[i])
        IDLE: begin
          cnt_nxt[i] = '0;
          if (syn_q[i] && enable[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              fsm_nxt[i] = LATCHED;
            end else begin
              fsm_nxt[i] = QUAL;
              cnt_nxt[i] = CNT_W'(1);
            end
          end
        end
        QUAL: begin
          if (!syn_q[i] || !enable[i]) begin
            fsm_nxt[i] = IDLE;
            cnt_nxt[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            fsm_nxt[i] = LATCHED;
            cnt_nxt[i] = '0;
          end else begin
            cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        LATCHED: begin
          if (ack[i]) begin
            fsm_nxt[i] = syn_q[i] ? WAIT_LOW : IDLE;
          end
        end
        WAIT_LOW: begin
          if (!syn_q[i]) begin
            fsm_nxt[i] = IDLE;
          end
        end
        default: begin
          fsm_nxt[i] = IDLE;
          cnt_nxt[i] = '0;
        end
      endcase
      latch_nxt[i] = (fsm_nxt[i] == LATCHED);
    end
    vis_nxt = force_all ? 3'b111 : latch_nxt;
  end

  // prev_q trails `state` by one cycle so the change strobe lands the cycle after the change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      syn_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        fsm_q[i] <= IDLE;
        cnt_q[i] <= '0;
      end
      state     <= '0;
      any_alarm <= 1'b0;
      prev_q    <= '0;
      state_chg <= 1'b0;
    end else begin
      sync1_q   <= raw;
      syn_q     <= sync1_q;
      fsm_q     <= fsm_nxt;
      cnt_q     <= cnt_nxt;
      state     <= vis_nxt;
      any_alarm <= |vis_nxt;
      prev_q    <= state;
      state_chg <= (state != prev_q);
    end
  end

endmodule
